// File: rtl/cpu_region_mapper_pkg.sv
// ============================================================================
// Package : m92_pkg
// Shared types, widths and default region table for cpu_region_mapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package m92_pkg;

  // The entry struct depends on these, so they live here rather than as module parameters.
  localparam int CPU_AW = 20;
  localparam int SDR_AW = 25;
  localparam int DEV_W  = 3;

  typedef enum logic [1:0] {
    KIND_OFF = 2'd0,
    KIND_ROM = 2'd1,
    KIND_RAM = 2'd2,
    KIND_DEV = 2'd3
  } region_kind_e;

  typedef struct packed {
    logic [CPU_AW-1:0] match;
    logic [CPU_AW-1:0] mask;
    logic [SDR_AW-1:0] sdr_base;
    region_kind_e      kind;
    logic              bankable;
    logic [DEV_W-1:0]  dev_idx;
  } region_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_SDR_WAIT = 3'd2,
    ST_DEV      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_OK       = 2'd0,
    RES_WRPROT   = 2'd1,
    RES_UNMAPPED = 2'd2,
    RES_TIMEOUT  = 2'd3
  } result_e;

  localparam logic [SDR_AW-1:0] REGION_BIOS_BASE = 25'h010_0000;
  localparam logic [SDR_AW-1:0] REGION_RAM_BASE  = 25'h020_0000;
  localparam logic [SDR_AW-1:0] REGION_CART_BASE = 25'h030_0000;

  // Boot-time table the system top loads through cfg_wr after reset.
  function automatic region_entry_t default_entry(input int unsigned idx);
    region_entry_t e;
    e = '0;
    case (idx)
      0: e = '{match: 20'hE0000, mask: 20'hE0000, sdr_base: REGION_BIOS_BASE,
               kind: KIND_ROM, bankable: 1'b0, dev_idx: '0};
      1: e = '{match: 20'h00000, mask: 20'hC0000, sdr_base: REGION_RAM_BASE,
               kind: KIND_RAM, bankable: 1'b0, dev_idx: '0};
      2: e = '{match: 20'h80000, mask: 20'hC0000, sdr_base: REGION_CART_BASE,
               kind: KIND_ROM, bankable: 1'b1, dev_idx: '0};
      3: e = '{match: 20'hD8000, mask: 20'hF8000, sdr_base: '0,
               kind: KIND_DEV, bankable: 1'b0, dev_idx: 3'd0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_region_mapper_if.sv
// ============================================================================
// Interface : cpu_region_mapper_if
// CPU bus-cycle strobes/ready and the SDRAM req/ack channel.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface cpu_region_mapper_if;
  import m92_pkg::*;

  logic [CPU_AW-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [SDR_AW-1:0] mem_addr;
  logic              mem_ack;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, mem_ack,
    input  cpu_ready, mem_req, mem_we, mem_addr
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, mem_ack,
    output cpu_ready, mem_req, mem_we, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/cpu_region_mapper_matcher.sv
// ============================================================================
// Module  : region_matcher
// Priority region hit and effective SDRAM address over the region table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module region_matcher
  import m92_pkg::*;
#(
  parameter int N_REGIONS = 8,
  parameter int BANK_W    = 4,
  parameter int BANK_LSB  = 16,
  parameter int N_DEV     = 6
) (
  input  region_entry_t     regions [N_REGIONS],
  input  logic [CPU_AW-1:0] addr,
  input  logic [BANK_W-1:0] bank,
  output logic              hit,
  output region_kind_e      kind,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic [N_DEV-1:0]  dev_onehot,
  output logic              dev_ok
);

  region_entry_t     w_sel;
  logic [CPU_AW-1:0] w_eff;
  logic [CPU_AW-1:0] w_keep;

  always_comb begin
    hit   = 1'b0;
    w_sel = '0;
    // Walk from the bottom up so the lowest-index hit is the one left standing.
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (regions[i].kind != KIND_OFF &&
          ((addr ^ regions[i].match) & regions[i].mask) == '0) begin
        hit   = 1'b1;
        w_sel = regions[i];
      end
    end

    w_eff  = addr;
    w_keep = ~w_sel.mask;
    // Substituted bank bits always reach the offset, even where the mask covers them.
    if (w_sel.bankable) begin
      w_eff[BANK_LSB +: BANK_W]  = bank;
      w_keep[BANK_LSB +: BANK_W] = '1;
    end

    sdr_addr   = w_sel.sdr_base + SDR_AW'(w_eff & w_keep);
    kind       = w_sel.kind;
    dev_ok     = int'(w_sel.dev_idx) < N_DEV;
    dev_onehot = dev_ok ? (N_DEV'(1) << w_sel.dev_idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_region_mapper.sv
// ============================================================================
// Module  : cpu_region_mapper
// Latches CPU bus cycles, decodes them through a loadable region table and
// runs the SDRAM handshake or a device-select pulse before returning ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_region_mapper
  import m92_pkg::*;
#(
  parameter int N_REGIONS = 8,
  parameter int BANK_W    = 4,
  parameter int BANK_LSB  = 16,
  parameter int N_DEV     = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  cpu_region_mapper_if.slave           bus,
  input  logic                         bank_wr,
  input  logic [BANK_W-1:0]            bank_din,
  input  logic                         cfg_wr,
  input  logic [$clog2(N_REGIONS)-1:0] cfg_idx,
  input  region_entry_t                cfg_entry,
  output logic [N_DEV-1:0]             dev_sel,
  output logic                         err_wrprot,
  output logic                         err_unmapped,
  output logic                         err_timeout
);

  state_e            r_state;
  state_e            w_state_nxt;
  result_e           r_res;
  result_e           w_res_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_latch;
  logic [CPU_AW-1:0] r_addr;
  logic              r_wr;
  logic [BANK_W-1:0] r_bank;
  region_entry_t     r_regions [N_REGIONS];
  logic [SDR_AW-1:0] r_mem_addr;
  logic [N_DEV-1:0]  r_dev_onehot;

  logic              w_hit;
  region_kind_e      w_kind;
  logic [SDR_AW-1:0] w_sdr_addr;
  logic [N_DEV-1:0]  w_dev_onehot;
  logic              w_dev_ok;

  region_matcher #(
    .N_REGIONS (N_REGIONS),
    .BANK_W    (BANK_W),
    .BANK_LSB  (BANK_LSB),
    .N_DEV     (N_DEV)
  ) u_matcher (
    .regions    (r_regions),
    .addr       (r_addr),
    .bank       (r_bank),
    .hit        (w_hit),
    .kind       (w_kind),
    .sdr_addr   (w_sdr_addr),
    .dev_onehot (w_dev_onehot),
    .dev_ok     (w_dev_ok)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_res_nxt     = r_res;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = r_mem_addr;
    dev_sel       = '0;
    err_wrprot    = 1'b0;
    err_unmapped  = 1'b0;
    err_timeout   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_rd || bus.cpu_wr) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_res_nxt = RES_OK;
        w_cnt_nxt = '0;
        if (!w_hit) begin
          w_res_nxt   = RES_UNMAPPED;
          w_state_nxt = ST_DONE;
        end else begin
          case (w_kind)
            KIND_ROM: begin
              if (r_wr) begin
                w_res_nxt   = RES_WRPROT;
                w_state_nxt = ST_DONE;
              end else begin
                w_state_nxt = ST_SDR_WAIT;
              end
            end
            KIND_RAM: w_state_nxt = ST_SDR_WAIT;
            KIND_DEV: begin
              if (w_dev_ok) begin
                w_state_nxt = ST_DEV;
              end else begin
                w_res_nxt   = RES_UNMAPPED;
                w_state_nxt = ST_DONE;
              end
            end
            default: begin
              w_res_nxt   = RES_UNMAPPED;
              w_state_nxt = ST_DONE;
            end
          endcase
        end
      end

      ST_SDR_WAIT: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = r_wr;
        if (bus.mem_ack) begin
          w_state_nxt = ST_DONE;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_res_nxt   = RES_TIMEOUT;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_DEV: begin
        dev_sel     = r_dev_onehot;
        w_state_nxt = ST_DONE;
      end

      ST_DONE: begin
        bus.cpu_ready = 1'b1;
        err_wrprot    = (r_res == RES_WRPROT);
        err_unmapped  = (r_res == RES_UNMAPPED);
        err_timeout   = (r_res == RES_TIMEOUT);
        w_state_nxt   = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_res        <= RES_OK;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_bank       <= '0;
      r_mem_addr   <= '0;
      r_dev_onehot <= '0;
      for (int i = 0; i < N_REGIONS; i++) begin
        r_regions[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_res   <= w_res_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr <= bus.cpu_addr;
        r_wr   <= bus.cpu_wr & ~bus.cpu_rd;
      end
      // Captured once per cycle so mem_addr cannot move while mem_req is up.
      if (r_state == ST_DECODE) begin
        r_mem_addr   <= w_sdr_addr;
        r_dev_onehot <= w_dev_onehot;
      end
      if (bank_wr) begin
        r_bank <= bank_din;
      end
      if (cfg_wr) begin
        r_regions[cfg_idx] <= cfg_entry;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_region_mapper.sv
// ============================================================================
// Module  : tb_cpu_region_mapper
// Directed stimulus with a queue scoreboard checked on each cpu_ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_region_mapper;
  import m92_pkg::*;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          bank_wr = 1'b0;
  logic [3:0]    bank_din = '0;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_idx = '0;
  region_entry_t cfg_entry = '0;
  logic [5:0]    dev_sel;
  logic          err_wrprot, err_unmapped, err_timeout;

  always #5 clk_sys = ~clk_sys;

  cpu_region_mapper_if bus ();

  cpu_region_mapper dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .bus          (bus),
    .bank_wr      (bank_wr),
    .bank_din     (bank_din),
    .cfg_wr       (cfg_wr),
    .cfg_idx      (cfg_idx),
    .cfg_entry    (cfg_entry),
    .dev_sel      (dev_sel),
    .err_wrprot   (err_wrprot),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    int          lat;
    int          nreq;
    logic [24:0] addr;
    logic        we;
    logic [5:0]  dev;
    logic [2:0]  err;   // {timeout, unmapped, wrprot}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ack_mode = 0;   // 0: ack at once, 1: never, 2: ack one cycle after req drops
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int lat, input int nreq, input logic [24:0] a,
                              input logic we, input logic [5:0] dev, input logic [2:0] err);
    exp_t e;
    e.lat = lat; e.nreq = nreq; e.addr = a; e.we = we; e.dev = dev; e.err = err;
    return e;
  endfunction

  // Memory responder
  always @(negedge clk_sys) begin
    case (ack_mode)
      0:       bus.mem_ack = bus.mem_req;
      1:       bus.mem_ack = 1'b0;
      default: bus.mem_ack = prev_req && !bus.mem_req;
    endcase
    prev_req = bus.mem_req;
  end

  // Monitor
  int          cyc = 0;
  int          t0 = 0;
  int          nreq = 0;
  logic        busy = 1'b0;
  logic [24:0] m_addr;
  logic        m_we, m_stable;
  logic [5:0]  m_dev;
  logic [2:0]  m_err;

  always @(negedge clk_sys) begin : monitor
    exp_t e;
    cyc++;
    if (!reset_n) begin
      busy = 1'b0;
    end else if (!busy) begin
      check("idle_outputs", {bus.cpu_ready, bus.mem_req, dev_sel, err_timeout, err_unmapped, err_wrprot}, '0);
      if (bus.cpu_rd || bus.cpu_wr) begin
        busy = 1'b1; t0 = cyc; nreq = 0; m_stable = 1'b1;
        m_dev = '0; m_err = '0; m_addr = '0; m_we = 1'b0;
      end
    end else begin
      if (bus.mem_req) begin
        if (nreq == 0) begin
          m_addr = bus.mem_addr; m_we = bus.mem_we;
        end else if (bus.mem_addr !== m_addr || bus.mem_we !== m_we) begin
          m_stable = 1'b0;
        end
        nreq++;
      end
      m_dev |= dev_sel;
      m_err |= {err_timeout, err_unmapped, err_wrprot};
      if (bus.cpu_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready: got ready with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          check("latency", cyc - t0, e.lat);
          check("req_cycles", nreq, e.nreq);
          if (e.nreq > 0) begin
            check("mem_addr", m_addr, e.addr);
            check("mem_we", m_we, e.we);
            check("addr_stable", m_stable, 1'b1);
          end
          check("dev_sel", m_dev, e.dev);
          check("errors", m_err, e.err);
        end
        busy = 1'b0;
      end else if (cyc - t0 > 400) begin
        checks++; failures++;
        $display("FAIL ready_timeout: no ready after %0d cycles", cyc - t0);
        busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [19:0] match, input logic [19:0] mask,
                     input logic [24:0] base, input region_kind_e kind, input logic bankable,
                     input logic [2:0] dev_idx);
    cfg_wr = 1'b1; cfg_idx = idx;
    cfg_entry = '{match: match, mask: mask, sdr_base: base, kind: kind, bankable: bankable, dev_idx: dev_idx};
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic issue(input logic [19:0] a, input logic rd, input logic wr, input exp_t e, input bit push);
    if (push) q.push_back(e);
    bus.cpu_addr = a; bus.cpu_rd = rd; bus.cpu_wr = wr;
    tick();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || q.size() != 0) && n < 600) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 600) begin
      checks++; failures++;
      $display("FAIL wait_done: transaction still open after %0d cycles", n);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.cpu_ready, bus.mem_req, bus.mem_we, bus.mem_addr, dev_sel,
                 err_timeout, err_unmapped, err_wrprot}, '0);
  endtask

  initial begin
    int n;
    bus.cpu_addr = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_outputs");
    reset_n = 1'b1;
    tick();

    // Plain ROM read with immediate ack
    cfg(3'd0, 20'hC0000, 20'hF0000, 25'h100000, KIND_ROM, 1'b0, 3'd0);
    issue(20'hC1234, 1'b1, 1'b0, mk(3, 1, 25'h101234, 1'b0, 6'b0, 3'b000), 1'b1);
    wait_done();

    // Bank substitution, then a bank rewrite in the strobe cycle
    bank_wr = 1'b1; bank_din = 4'd5; tick(); bank_wr = 1'b0;
    cfg(3'd1, 20'hA0000, 20'hE0000, 25'h0, KIND_ROM, 1'b1, 3'd0);
    issue(20'hA0010, 1'b1, 1'b0, mk(3, 1, 25'h050010, 1'b0, 6'b0, 3'b000), 1'b1);
    wait_done();
    bank_wr = 1'b1; bank_din = 4'd3;
    issue(20'hA0010, 1'b1, 1'b0, mk(3, 1, 25'h030010, 1'b0, 6'b0, 3'b000), 1'b1);
    bank_wr = 1'b0;
    wait_done();

    // ROM write protection and unmapped access
    issue(20'hC0004, 1'b0, 1'b1, mk(2, 0, 25'h0, 1'b0, 6'b0, 3'b001), 1'b1);
    wait_done();
    issue(20'hF4000, 1'b1, 1'b0, mk(2, 0, 25'h0, 1'b0, 6'b0, 3'b010), 1'b1);
    wait_done();

    // Overlapping entries: lower index (RAM) wins
    cfg(3'd1, 20'hD0000, 20'hF0000, 25'h200000, KIND_RAM, 1'b0, 3'd0);
    cfg(3'd4, 20'hD0000, 20'hF0000, 25'h300000, KIND_ROM, 1'b0, 3'd0);
    issue(20'hD0040, 1'b0, 1'b1, mk(3, 1, 25'h200040, 1'b1, 6'b0, 3'b000), 1'b1);
    wait_done();
    issue(20'hD0040, 1'b1, 1'b0, mk(3, 1, 25'h200040, 1'b0, 6'b0, 3'b000), 1'b1);
    wait_done();

    // Device entry written in the same cycle as the strobe
    cfg_wr = 1'b1; cfg_idx = 3'd2;
    cfg_entry = '{match: 20'hF8000, mask: 20'hF8000, sdr_base: 25'h0, kind: KIND_DEV, bankable: 1'b0, dev_idx: 3'd2};
    issue(20'hF8010, 1'b1, 1'b0, mk(3, 0, 25'h0, 1'b0, 6'b000100, 3'b000), 1'b1);
    cfg_wr = 1'b0;
    wait_done();
    cfg(3'd3, 20'h90000, 20'hF0000, 25'h0, KIND_DEV, 1'b0, 3'd7);
    issue(20'h90000, 1'b1, 1'b0, mk(2, 0, 25'h0, 1'b0, 6'b0, 3'b010), 1'b1);
    wait_done();

    // Timeout, late ack ignored, next access served normally
    ack_mode = 2;
    issue(20'hC0100, 1'b1, 1'b0, mk(257, 255, 25'h100100, 1'b0, 6'b0, 3'b100), 1'b1);
    wait_done();
    repeat (3) tick();
    ack_mode = 0;
    issue(20'hC0200, 1'b1, 1'b0, mk(3, 1, 25'h100200, 1'b0, 6'b0, 3'b000), 1'b1);
    wait_done();

    // Reset in the middle of an SDRAM wait
    ack_mode = 1;
    issue(20'hC0300, 1'b1, 1'b0, mk(0, 0, 25'h0, 1'b0, 6'b0, 3'b000), 1'b0);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    check("req_before_reset", bus.mem_req, 1'b1);
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    tick();
    check("reset_drops_req", bus.mem_req, 1'b0);
    tick();
    check_reset_outputs("midreset_outputs");
    reset_n = 1'b1;
    ack_mode = 0;
    repeat (5) tick();

    // Table cleared by reset; rd+wr together is a read
    issue(20'hC0000, 1'b1, 1'b1, mk(2, 0, 25'h0, 1'b0, 6'b0, 3'b010), 1'b1);
    wait_done();
    cfg(3'd0, 20'hC0000, 20'hF0000, 25'h100000, KIND_ROM, 1'b0, 3'd0);
    issue(20'hC0008, 1'b1, 1'b1, mk(3, 1, 25'h100008, 1'b0, 6'b0, 3'b000), 1'b1);
    wait_done();

    repeat (3) tick();
    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
